// File: rtl/axi_dma_mem_slave.sv
// axi_dma_mem_slave
// Single-beat AXI4 memory slave used as the DMA target and as on-chip scratch RAM.
// Read channel: R_IDLE -> R_WAIT -> R_DATA, one outstanding read, READ_LATENCY cycles
// from the AR handshake cycle to the first rvalid cycle.
// Write channel: W_IDLE -> W_RESP, AW and W accepted in any order.
// Out-of-range accesses return SLVERR; out-of-range writes never touch the array.
// Optional feature macro: AXI_MEM_BACKPRESSURE_EN adds LFSR-driven stalls on
// arready/awready/wready to exercise master stall handling.
`timescale 1ns/1ps

module axi_dma_mem_slave #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_DEPTH    = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready
);

    localparam int OFFS = $clog2(DATA_WIDTH / 8);
    localparam int IDXW = $clog2(MEM_DEPTH);
    localparam int CNTW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * (DATA_WIDTH / 8));
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic       {W_IDLE, W_RESP}         w_state_t;

    // Byte addresses at or beyond the array size get SLVERR.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < MEM_BYTES);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Read channel state
    r_state_t              r_state_reg;
    logic [CNTW-1:0]       rd_cnt_reg;
    logic                  arready_reg;
    logic                  rvalid_reg;
    logic [1:0]            rresp_reg;
    logic                  rd_ok_reg;
    logic [DATA_WIDTH-1:0] rd_word_reg;

    // Write channel state
    w_state_t              w_state_reg;
    logic                  awready_reg;
    logic                  wready_reg;
    logic                  aw_held_reg;
    logic                  w_held_reg;
    logic [ADDR_WIDTH-1:0] awaddr_hold_reg;
    logic [DATA_WIDTH-1:0] wdata_hold_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;

    logic                  ar_fire;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  have_aw;
    logic                  have_w;
    logic                  commit;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  ar_in_range;
    logic                  wr_in_range;

`ifdef AXI_MEM_BACKPRESSURE_EN
    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;
    logic [2:0]  block_reg;
    logic [2:0]  block_next;

    // Next LFSR value and per-ready stall masks; a ready that a waiting valid
    // has already seen is never masked, so an offered transfer always completes.
    always_comb begin
        lfsr_next     = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        block_next[0] = lfsr_next[0] && !(arvalid && !arready);
        block_next[1] = lfsr_next[1] && !(awvalid && !awready);
        block_next[2] = lfsr_next[2] && !(wvalid  && !wready);
    end

    // Stall generator state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg  <= 16'hACE1;
            block_reg <= 3'b000;
        end else begin
            lfsr_reg  <= lfsr_next;
            block_reg <= block_next;
        end
    end

    assign arready = arready_reg & ~block_reg[0];
    assign awready = awready_reg & ~block_reg[1];
    assign wready  = wready_reg  & ~block_reg[2];
`else
    assign arready = arready_reg;
    assign awready = awready_reg;
    assign wready  = wready_reg;
`endif

    assign rvalid = rvalid_reg;
    assign rresp  = rresp_reg;
    assign bvalid = bvalid_reg;
    assign bresp  = bresp_reg;
    // The RAM output register has no reset; rd_ok_reg forces rdata to zero in
    // reset and for out-of-range reads.
    assign rdata  = rd_ok_reg ? rd_word_reg : '0;

    // Handshakes and the write commit (the edge where both AW and W are held).
    always_comb begin
        ar_fire     = arvalid && arready;
        aw_fire     = awvalid && awready;
        w_fire      = wvalid && wready;
        have_aw     = aw_held_reg || aw_fire;
        have_w      = w_held_reg || w_fire;
        wr_addr     = aw_held_reg ? awaddr_hold_reg : awaddr;
        wr_data     = w_held_reg ? wdata_hold_reg : wdata;
        ar_in_range = in_range(araddr);
        wr_in_range = in_range(wr_addr);
        commit      = (w_state_reg == W_IDLE) && have_aw && have_w;
        mem_we      = commit && wr_in_range;
    end

    // Block RAM: write port plus registered read captured on the AR handshake;
    // a same-edge write to the same word leaves the read with the old data.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr[OFFS +: IDXW]] <= wr_data;
        end
        if (ar_fire) begin
            rd_word_reg <= mem[araddr[OFFS +: IDXW]];
        end
    end

    // Read FSM: accept AR, wait out the latency, hold R until rready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_reg <= R_IDLE;
            rd_cnt_reg  <= '0;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rresp_reg   <= RESP_OKAY;
            rd_ok_reg   <= 1'b0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (ar_fire) begin
                        arready_reg <= 1'b0;
                        rd_ok_reg   <= ar_in_range;
                        rresp_reg   <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                        if (READ_LATENCY == 1) begin
                            r_state_reg <= R_DATA;
                            rvalid_reg  <= 1'b1;
                        end else begin
                            r_state_reg <= R_WAIT;
                            rd_cnt_reg  <= '0;
                        end
                    end else begin
                        arready_reg <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (rd_cnt_reg == CNTW'(READ_LATENCY - 2)) begin
                        r_state_reg <= R_DATA;
                        rvalid_reg  <= 1'b1;
                    end else begin
                        rd_cnt_reg <= rd_cnt_reg + 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        r_state_reg <= R_IDLE;
                        rvalid_reg  <= 1'b0;
                        arready_reg <= 1'b1;
                    end
                end
                default: begin
                    r_state_reg <= R_IDLE;
                    arready_reg <= 1'b0;
                    rvalid_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Write FSM: collect AW and W in either order, commit, then hold B until bready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_reg     <= W_IDLE;
            awready_reg     <= 1'b0;
            wready_reg      <= 1'b0;
            aw_held_reg     <= 1'b0;
            w_held_reg      <= 1'b0;
            awaddr_hold_reg <= '0;
            wdata_hold_reg  <= '0;
            bvalid_reg      <= 1'b0;
            bresp_reg       <= RESP_OKAY;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (commit) begin
                        w_state_reg <= W_RESP;
                        bvalid_reg  <= 1'b1;
                        bresp_reg   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                        awready_reg <= 1'b0;
                        wready_reg  <= 1'b0;
                        aw_held_reg <= 1'b0;
                        w_held_reg  <= 1'b0;
                    end else begin
                        if (aw_fire) begin
                            aw_held_reg     <= 1'b1;
                            awaddr_hold_reg <= awaddr;
                        end
                        if (w_fire) begin
                            w_held_reg     <= 1'b1;
                            wdata_hold_reg <= wdata;
                        end
                        awready_reg <= !have_aw;
                        wready_reg  <= !have_w;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        w_state_reg <= W_IDLE;
                        bvalid_reg  <= 1'b0;
                        awready_reg <= 1'b1;
                        wready_reg  <= 1'b1;
                    end
                end
                default: begin
                    w_state_reg <= W_IDLE;
                    bvalid_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_dma_mem_slave.sv
// Testbench for axi_dma_mem_slave: table of single-beat writes/reads checked through
// a B/R scoreboard, plus hand-written sequences for W-before-AW, R backpressure,
// same-edge read/write and reset during a read.
`timescale 1ns/1ps

module tb_axi_dma_mem_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    always #5 clk = ~clk;

    axi_dma_mem_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .READ_LATENCY(2)
    ) dut (
        .clk(clk), .reset(reset),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } vec_t;

    int          n_vec = 0;
    int          n_miss = 0;
    r_exp_t      r_q[$];
    logic [1:0]  b_q[$];
    r_exp_t      mon_r;
    logic [1:0]  mon_b;
    vec_t        vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pop and compare whenever a B or R handshake is about to happen.
    always @(negedge clk) begin
        if (!reset) begin
            if (bvalid && bready) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected", 32'(bvalid), 32'd0);
                end else begin
                    mon_b = b_q.pop_front();
                    check("bresp", 32'(bresp), 32'(mon_b));
                    $display("B  resp=%b", bresp);
                end
            end
            if (rvalid && rready) begin
                if (r_q.size() == 0) begin
                    check("r_unexpected", 32'(rvalid), 32'd0);
                end else begin
                    mon_r = r_q.pop_front();
                    check("rdata", rdata, mon_r.data);
                    check("rresp", 32'(rresp), 32'(mon_r.resp));
                    $display("R  data=0x%h resp=%b", rdata, rresp);
                end
            end
        end
    end

    // Wait (bounded) for a ready on channel ch: 0=AR, 1=AW, 2=W; the valid is already up.
    task automatic hs(input int ch, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if ((ch == 0 && arready) || (ch == 1 && awready) || (ch == 2 && wready)) ok = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] exp_resp);
        bit aw_done = 1'b0;
        bit w_done = 1'b0;
        bit aw_ok;
        bit w_ok;
        b_q.push_back(exp_resp);
        $display("W  addr=0x%h data=0x%h", addr, data);
        bready  = 1'b1;
        awaddr  = addr;
        wdata   = data;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int n = 0; n < 50 && !(aw_done && w_done); n++) begin
            @(negedge clk);
            aw_ok = awvalid && awready;
            w_ok  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_ok) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_ok)  begin wvalid  = 1'b0; w_done  = 1'b1; end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("aw_w_handshake", 32'(aw_done && w_done), 32'd1);
        @(negedge clk);
        check("b_latency", 32'(bvalid), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input int stall);
        bit ok;
        r_q.push_back('{exp_data, exp_resp});
        $display("AR addr=0x%h stall=%0d", addr, stall);
        rready  = (stall == 0);
        araddr  = addr;
        arvalid = 1'b1;
        hs(0, ok);
        arvalid = 1'b0;
        check("ar_handshake", 32'(ok), 32'd1);
        @(negedge clk);
        check("r_wait_low", 32'(rvalid), 32'd0);
        @(negedge clk);
        check("r_latency", 32'(rvalid), 32'd1);
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                if (i > 0) @(negedge clk);
                check("r_hold_valid", 32'(rvalid), 32'd1);
                check("r_hold_data", rdata, exp_data);
                check("ar_blocked", 32'(arready), 32'd0);
            end
            @(posedge clk); #1;
            rready = 1'b1;
            @(negedge clk);
            @(posedge clk); #1;
            @(negedge clk);
`ifndef AXI_MEM_BACKPRESSURE_EN
            check("ar_reopen", 32'(arready), 32'd1);
`endif
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bit ok;
        bit seen;

        vecs = '{
            '{1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 2'b00},
            '{1'b0, 32'h0000_0010, 32'hA5A5_A5A5, 2'b00},
            '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 2'b00},
            '{1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 2'b10},
            '{1'b0, 32'h0000_0400, 32'h0000_0000, 2'b10},
            '{1'b0, 32'h0000_0000, 32'h0BAD_F00D, 2'b00},
            '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 2'b00},
            '{1'b0, 32'h0000_03FE, 32'hCAFE_F00D, 2'b00},
            '{1'b1, 32'h0000_0017, 32'h1122_3344, 2'b00},
            '{1'b0, 32'h0000_0014, 32'h1122_3344, 2'b00},
            '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 2'b10},
            '{1'b1, 32'h0000_1000, 32'h0000_0055, 2'b10},
            '{1'b0, 32'h0000_0000, 32'h0BAD_F00D, 2'b00}
        };

        // Reset: outputs low while held, readies rise on the first edge after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 32'({arready, awready, wready, rvalid, bvalid, rresp, bresp}), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_before_edge", 32'({arready, awready, wready}), 32'd0);
        @(negedge clk);
`ifndef AXI_MEM_BACKPRESSURE_EN
        check("ready_after_reset", 32'({arready, awready, wready}), 32'd7);
`endif
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].resp);
            else            do_read(vecs[i].addr, vecs[i].data, vecs[i].resp, 0);
        end

`ifndef AXI_MEM_BACKPRESSURE_EN
        // Same-edge AR and write commit to one word: the read sees the old value.
        do_write(32'h30, 32'h0000_0001, 2'b00);
        fork
            do_write(32'h30, 32'h0000_0002, 2'b00);
            do_read(32'h30, 32'h0000_0001, 2'b00, 0);
        join
        do_read(32'h30, 32'h0000_0002, 2'b00, 0);
`endif

        // W accepted three cycles before AW.
        b_q.push_back(2'b00);
        $display("W  data=0x12345678 then AW addr=0x00000020");
        bready = 1'b1;
        wdata  = 32'h1234_5678;
        wvalid = 1'b1;
        hs(2, ok);
        wvalid = 1'b0;
        check("w_first_handshake", 32'(ok), 32'd1);
        @(negedge clk);
        check("wready_low_after_w", 32'(wready), 32'd0);
        check("no_early_bvalid", 32'(bvalid), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        awaddr  = 32'h20;
        awvalid = 1'b1;
        hs(1, ok);
        awvalid = 1'b0;
        check("aw_late_handshake", 32'(ok), 32'd1);
        @(negedge clk);
        check("b_after_aw", 32'(bvalid), 32'd1);
        @(posedge clk); #1;
        do_read(32'h20, 32'h1234_5678, 2'b00, 0);

        // R backpressure: hold rready low for five rvalid cycles.
        do_read(32'h10, 32'hA5A5_A5A5, 2'b00, 5);

        // Reset during R_WAIT drops the read.
        $display("AR addr=0x00000010 then reset in R_WAIT");
        rready  = 1'b1;
        araddr  = 32'h10;
        arvalid = 1'b1;
        hs(0, ok);
        arvalid = 1'b0;
        check("rst_ar_handshake", 32'(ok), 32'd1);
        reset = 1'b1;
        seen  = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen = seen | rvalid;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | rvalid;
        end
        check("rst_no_rvalid", 32'(seen), 32'd0);
        @(posedge clk); #1;
        do_read(32'h10, 32'hA5A5_A5A5, 2'b00, 0);

        repeat (3) @(posedge clk);
        check("sb_drain", 32'(r_q.size() + b_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
